// File: rtl/loop_cpu_core.sv
// Two-cycle-per-instruction control-loop sequencer: loadable IMEM, 16-entry register
// file, wrapping/saturating ALU, branches, ADC-wait handshake and periodic restart timer.
module loop_cpu_core #(
    parameter int DW         = 18,
    parameter int IMEM_DEPTH = 16,
    parameter int N_IN       = 2,
    parameter int N_OUT      = 1,
    parameter int PERIOD_CYC = 500000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_en,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic [N_IN*DW-1:0]            in_ch,
    input  logic                          adc_valid,
    output logic [N_OUT*DW-1:0]           out_ch,
    output logic                          adc_start,
    output logic                          running,
    output logic                          overrun
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int TW = $clog2(PERIOD_CYC);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_IN    = 6'h10;
    localparam logic [5:0] OP_OUT   = 6'h11;
    localparam logic [5:0] OP_WAIT  = 6'h12;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDS = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBS = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_ADC, HALT} state_t;

    state_t         state;
    logic [31:0]    imem [IMEM_DEPTH];
    logic [31:0]    instr_p1;
    logic [DW-1:0]  rf [16];
    logic [AW-1:0]  pc;
    logic [TW-1:0]  timer;
    logic           prog_en_q;
    logic           tick;

    logic [5:0]     opcode, funct;
    logic [3:0]     rs, rt, rd;
    logic [15:0]    imm;
    logic [7:0]     ch_idx;
    logic [DW-1:0]  rs_val, rt_val, imm_ext, in_sel, alu_res;
    logic [3:0]     wb_addr;
    logic           wb_en, br_taken;
    logic [AW-1:0]  pc_inc, pc_next;
    logic           unused_bits;

    function automatic logic [DW-1:0] sext16(input logic [15:0] v);
        logic [DW+15:0] w;
        w = {{DW{v[15]}}, v};
        return w[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_addsub(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b,
                                                 input logic                 sub);
        logic signed [DW:0] s;
        s = sub ? ({a[DW-1], a} - {b[DW-1], b}) : ({a[DW-1], a} + {b[DW-1], b});
        if (s[DW] != s[DW-1])
            return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return s[DW-1:0];
    endfunction

    assign opcode      = instr_p1[31:26];
    assign rs          = instr_p1[24:21];
    assign rt          = instr_p1[19:16];
    assign rd          = instr_p1[14:11];
    assign funct       = instr_p1[5:0];
    assign imm         = instr_p1[15:0];
    assign ch_idx      = imm[7:0];
    assign unused_bits = ^{instr_p1[25], instr_p1[20]};

    assign rs_val  = (rs == 4'd0) ? '0 : rf[rs];
    assign rt_val  = (rt == 4'd0) ? '0 : rf[rt];
    assign imm_ext = sext16(imm);
    assign tick    = (timer == TW'(PERIOD_CYC - 1));

    assign br_taken = ((opcode == OP_BEQ) && (rs_val == rt_val)) ||
                      ((opcode == OP_BNE) && (rs_val != rt_val));
    assign pc_inc   = pc + AW'(1);
    assign pc_next  = br_taken ? (pc_inc + imm[AW-1:0]) : pc_inc;

    // Discarded by a coincident tick, so the ADC never sees a request from a dropped WAIT.
    assign adc_start = (state == EXEC) && (opcode == OP_WAIT) && !tick;

    always_comb begin
        in_sel = '0;
        for (int k = 0; k < N_IN; k++)
            if (ch_idx == 8'(k)) in_sel = in_ch[k*DW +: DW];
    end

    always_comb begin
        alu_res = '0;
        wb_en   = 1'b0;
        wb_addr = rd;
        case (opcode)
            OP_RTYPE: begin
                wb_en = 1'b1;
                case (funct)
                    F_ADD:   alu_res = rs_val + rt_val;
                    F_SUB:   alu_res = rs_val - rt_val;
                    F_AND:   alu_res = rs_val & rt_val;
                    F_OR:    alu_res = rs_val | rt_val;
                    F_ADDS:  alu_res = sat_addsub(rs_val, rt_val, 1'b0);
                    F_SUBS:  alu_res = sat_addsub(rs_val, rt_val, 1'b1);
                    default: wb_en = 1'b0;
                endcase
            end
            OP_ADDI: begin
                wb_en   = 1'b1;
                wb_addr = rt;
                alu_res = rs_val + imm_ext;
            end
            OP_IN: begin
                wb_en   = 1'b1;
                wb_addr = rt;
                alu_res = in_sel;
            end
            default: ;
        endcase
    end

    // Stage 0 -> 1: synchronous IMEM read in FETCH, instruction held for EXEC
    always_ff @(posedge clk) begin
        if (prog_en && prog_we) imem[prog_addr] <= prog_data;
        if (state == FETCH) instr_p1 <= imem[pc];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= '0;
            timer     <= '0;
            running   <= 1'b0;
            overrun   <= 1'b0;
            prog_en_q <= 1'b0;
            out_ch    <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            prog_en_q <= prog_en;
            if (prog_en) begin
                state   <= IDLE;
                pc      <= '0;
                timer   <= '0;
                running <= 1'b0;
            end else if (state == IDLE) begin
                if (prog_en_q) begin
                    state   <= FETCH;
                    running <= 1'b1;
                    overrun <= 1'b0;
                end
            end else if (tick) begin
                // Restart wins over any EXEC completion or adc_valid this cycle.
                state   <= FETCH;
                pc      <= '0;
                timer   <= '0;
                running <= 1'b1;
                if (state != HALT) overrun <= 1'b1;
            end else begin
                timer <= timer + TW'(1);
                case (state)
                    FETCH: state <= EXEC;
                    EXEC: begin
                        pc <= pc_next;
                        if (wb_en && (wb_addr != 4'd0)) rf[wb_addr] <= alu_res;
                        if (opcode == OP_OUT)
                            for (int k = 0; k < N_OUT; k++)
                                if (ch_idx == 8'(k)) out_ch[k*DW +: DW] <= rs_val;
                        if (opcode == OP_WAIT) begin
                            state <= WAIT_ADC;
                        end else if (opcode == OP_HALT) begin
                            state   <= HALT;
                            running <= 1'b0;
                        end else begin
                            state <= FETCH;
                        end
                    end
                    WAIT_ADC: if (adc_valid) state <= FETCH;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_loop_cpu_core.sv
// Directed bench for loop_cpu_core: ALU vector table plus hand-written sequences for
// restart timing, branches, ADC handshake, overrun and asynchronous reset.
module tb_loop_cpu_core;
    localparam int DW = 18;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [31:0] WAIT_W = 32'h4800_0000;

    logic                clk = 1'b0;
    logic                rst, prog_en, prog_we, adc_valid;
    logic [3:0]          prog_addr;
    logic [31:0]         prog_data;
    logic [2*DW-1:0]     in_ch;
    logic [DW-1:0]       out_ch;
    logic                adc_start, running, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] ch0;
        logic [DW-1:0] ch1;
        logic [31:0]   instr;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [16];

    always #5 clk = ~clk;

    loop_cpu_core #(
        .DW(DW), .IMEM_DEPTH(16), .N_IN(2), .N_OUT(1), .PERIOD_CYC(64)
    ) dut (
        .clk(clk), .rst(rst), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .in_ch(in_ch),
        .adc_valid(adc_valid), .out_ch(out_ch), .adc_start(adc_start),
        .running(running), .overrun(overrun)
    );

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 1'b0, 4'(rs), 1'b0, 4'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 1'b0, 4'(rs), 1'b0, 4'(rt), 1'b0, 4'(rd), 5'b0, 6'(fn)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic prog_begin();
        @(negedge clk);
        prog_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic ld(input int a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    // Drops prog_en; returns at the negedge inside the first FETCH cycle (cyc = 0).
    task automatic go();
        prog_en = 1'b0;
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst = 1'b0; prog_en = 1'b0; prog_we = 1'b0; adc_valid = 1'b0;
        prog_addr = '0; prog_data = '0; in_ch = '0;
        #1;
        chk("rst_out_ch",    32'(out_ch),    32'h0);
        chk("rst_adc_start", 32'(adc_start), 32'h0);
        chk("rst_running",   32'(running),   32'h0);
        chk("rst_overrun",   32'(overrun),   32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", 32'(running), 32'h0);

        // ALU table: IN r1,ch0; IN r2,ch1; <instr writing r3>; OUT ch0,r3; HALT.
        // Rows 9 and 13 rely on r3 left by the previous row.
        vecs[0]  = '{18'h1FFFF, 18'h00001, r_type(1, 2, 3, 'h20), 18'h20000};
        vecs[1]  = '{18'h1FFFF, 18'h00001, r_type(1, 2, 3, 'h21), 18'h1FFFF};
        vecs[2]  = '{18'h20000, 18'h00001, r_type(1, 2, 3, 'h23), 18'h20000};
        vecs[3]  = '{18'h20000, 18'h00001, r_type(1, 2, 3, 'h22), 18'h1FFFF};
        vecs[4]  = '{18'h2AAAA, 18'h0FF0F, r_type(1, 2, 3, 'h24), 18'h0AA0A};
        vecs[5]  = '{18'h20001, 18'h00010, r_type(1, 2, 3, 'h25), 18'h20011};
        vecs[6]  = '{18'h3FFFF, 18'h3FFFF, r_type(1, 2, 3, 'h21), 18'h3FFFE};
        vecs[7]  = '{18'h1FFFF, 18'h3FFFF, r_type(1, 2, 3, 'h23), 18'h1FFFF};
        vecs[8]  = '{18'h20000, 18'h3FFFF, r_type(1, 2, 3, 'h21), 18'h20000};
        vecs[9]  = '{18'h00001, 18'h00002, r_type(1, 2, 3, 'h3F), 18'h20000};
        vecs[10] = '{18'h00005, 18'h00007, r_type(1, 2, 3, 'h20), 18'h0000C};
        vecs[11] = '{18'h00000, 18'h00000, i_type('h08, 1, 3, 'hFFFF), 18'h3FFFF};
        vecs[12] = '{18'h00001, 18'h00000, i_type('h08, 1, 3, 'h7FFF), 18'h08000};
        vecs[13] = '{18'h00001, 18'h00002, i_type('h3E, 1, 3, 'h1234), 18'h08000};
        vecs[14] = '{18'h00001, 18'h00002, i_type('h10, 0, 3, 5), 18'h00000};
        vecs[15] = '{18'h00005, 18'h00007, r_type(1, 2, 3, 'h23), 18'h3FFFE};

        for (int i = 0; i < 16; i++) begin
            prog_begin();
            ld(0, i_type('h10, 0, 1, 0));
            ld(1, i_type('h10, 0, 2, 1));
            ld(2, vecs[i].instr);
            ld(3, i_type('h11, 3, 0, 0));
            ld(4, HALT_W);
            in_ch = {vecs[i].ch1, vecs[i].ch0};
            go();
            run_to(12);
            chk($sformatf("vec%0d_out", i),     32'(out_ch),  32'(vecs[i].exp));
            chk($sformatf("vec%0d_halted", i),  32'(running), 32'h0);
        end

        // Periodic loop: IN r1,ch1; OUT ch0,r1; HALT with a 64-cycle period.
        do_reset();
        prog_begin();
        ld(0, i_type('h10, 0, 1, 1));
        ld(1, i_type('h11, 1, 0, 0));
        ld(2, HALT_W);
        in_ch = {18'h00123, 18'h00000};
        go();
        run_to(3);  chk("loop_out_before", 32'(out_ch),  32'h0);
        run_to(4);  chk("loop_out_first",  32'(out_ch),  32'h123);
        run_to(5);  chk("loop_run_exec",   32'(running), 32'h1);
        run_to(6);  chk("loop_run_halt",   32'(running), 32'h0);
        run_to(40); in_ch = {18'h00456, 18'h00000};
        run_to(63); chk("loop_run_c63",    32'(running), 32'h0);
        chk("loop_out_c63",                32'(out_ch),  32'h123);
        run_to(64); chk("loop_run_c64",    32'(running), 32'h1);
        chk("loop_overrun",                32'(overrun), 32'h0);
        run_to(68); chk("loop_out_repeat", 32'(out_ch),  32'h456);

        // Branch skip and PC wrap: r7 counts loop iterations through word 15 -> 0.
        do_reset();
        prog_begin();
        ld(0, i_type('h08, 7, 7, 1));
        ld(1, i_type('h11, 7, 0, 0));
        ld(2, i_type('h04, 0, 0, 2));
        ld(3, i_type('h08, 0, 7, 'h100));
        ld(4, i_type('h11, 7, 0, 0));
        ld(5, i_type('h04, 0, 0, 9));
        for (int a = 6; a < 15; a++) ld(a, HALT_W);
        ld(15, 32'h0);
        go();
        run_to(4);  chk("wrap_iter1",  32'(out_ch), 32'h1);
        run_to(13); chk("wrap_hold1",  32'(out_ch), 32'h1);
        run_to(14); chk("wrap_iter2",  32'(out_ch), 32'h2);
        run_to(24); chk("wrap_iter3",  32'(out_ch), 32'h3);
        run_to(44); chk("wrap_iter5",  32'(out_ch), 32'h5);
        chk("wrap_running", 32'(running), 32'h1);

        // BNE self-loop without HALT: overrun at the tick, then restart from word 0.
        do_reset();
        prog_begin();
        ld(0, i_type('h10, 0, 1, 0));
        ld(1, i_type('h04, 0, 1, 5));
        ld(2, i_type('h08, 0, 2, 'h33));
        ld(3, i_type('h11, 2, 0, 0));
        ld(4, i_type('h05, 0, 1, 'hFFFF));
        ld(5, i_type('h08, 0, 2, 'h44));
        ld(6, i_type('h11, 2, 0, 0));
        ld(7, i_type('h11, 1, 0, 0));
        ld(8, HALT_W);
        in_ch = {18'h00000, 18'h00005};
        go();
        run_to(7);  chk("bne_out_before", 32'(out_ch),  32'h0);
        run_to(8);  chk("bne_out",        32'(out_ch),  32'h33);
        run_to(30); chk("bne_loop_out",   32'(out_ch),  32'h33);
        chk("bne_loop_run",               32'(running), 32'h1);
        run_to(40); in_ch = {18'h00000, 18'h00000};
        run_to(63); chk("ovr_c63",        32'(overrun), 32'h0);
        run_to(64); chk("ovr_c64",        32'(overrun), 32'h1);
        chk("ovr_run_c64",                32'(running), 32'h1);
        run_to(69); chk("ovr_out_c69",    32'(out_ch),  32'h33);
        run_to(70); chk("ovr_pc0_out",    32'(out_ch),  32'h0);
        run_to(72); chk("ovr_halted",     32'(running), 32'h0);
        run_to(140); chk("ovr_sticky",    32'(overrun), 32'h1);
        prog_begin();
        chk("ovr_kept_in_prog", 32'(overrun), 32'h1);
        go();
        chk("ovr_cleared", 32'(overrun), 32'h0);

        // ADC handshake: adc_valid coincident with adc_start is ignored.
        do_reset();
        prog_begin();
        ld(0, WAIT_W);
        ld(1, i_type('h08, 0, 2, 'h55));
        ld(2, i_type('h11, 2, 0, 0));
        ld(3, HALT_W);
        go();
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            run_to(k);
            if (adc_start) pulses++;
            if (k == 1) chk("adc_start_exec", 32'(adc_start), 32'h1);
            adc_valid = (k == 1);
        end
        chk("adc_single_pulse", 32'(pulses),   32'h1);
        chk("adc_wait_run",     32'(running),  32'h1);
        chk("adc_wait_out",     32'(out_ch),   32'h0);
        run_to(12); adc_valid = 1'b1;
        run_to(13); adc_valid = 1'b0;
        run_to(16); chk("adc_out_before", 32'(out_ch), 32'h0);
        run_to(17); chk("adc_out_after",  32'(out_ch), 32'h55);

        // Asynchronous reset while stalled in WAIT_ADC.
        prog_begin();
        go();
        run_to(5);
        chk("arst_pre_out", 32'(out_ch),  32'h55);
        chk("arst_pre_run", 32'(running), 32'h1);
        rst = 1'b0;
        #1;
        chk("arst_out",       32'(out_ch),    32'h0);
        chk("arst_running",   32'(running),   32'h0);
        chk("arst_adc_start", 32'(adc_start), 32'h0);
        chk("arst_overrun",   32'(overrun),   32'h0);
        @(negedge clk);
        rst = 1'b1;
        adc_valid = 1'b1;
        repeat (10) @(negedge clk);
        adc_valid = 1'b0;
        chk("arst_stays_idle", 32'(running), 32'h0);
        prog_begin();
        go();
        run_to(1);
        chk("arst_restart", 32'(adc_start), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
